// File: rtl/multiword_adder_pkg.sv
// Shared types and constants for the nibble-serial multiword adder.
package multiword_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int CHUNK = 4;

    // Counter width for NCHUNK nibbles; never narrower than one bit.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/multiword_adder_full_adder_n.sv
// 4-bit ripple adder stage driven one nibble per cycle by multiword_adder.
module multiword_adder_full_adder_n (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    assign {c_out, sum} = 5'(a) + 5'(b) + 5'(c_in);

endmodule

// File: rtl/multiword_adder.sv
// WIDTH-bit adder that reuses one 4-bit stage per cycle, carry fed back through carry_r.
module multiword_adder
    import multiword_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry_r;
    logic [CW-1:0]    cnt;
    logic [3:0]       nib_sum;
    logic             nib_c;
    logic             accept;
    logic             last_nib;

    multiword_adder_full_adder_n adder_nib (
        .a     (a_sh[3:0]),
        .b     (b_sh[3:0]),
        .c_in  (carry_r),
        .sum   (nib_sum),
        .c_out (nib_c)
    );

    assign last_nib = (cnt == CW'(NCHUNK - 1));

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (last_nib) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    in_ready  = 1'b1;
                    state_nxt = in_valid ? BUSY : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) in_ready = 1'b0;
    end

    assign accept = in_valid & in_ready;

    // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            carry_r <= 1'b0;
            res_sh  <= '0;
        end else if (accept) begin
            cnt     <= '0;
            carry_r <= c_in;
        end else if (state == BUSY) begin
            cnt     <= cnt + 1'b1;
            carry_r <= nib_c;
            res_sh  <= (res_sh >> CHUNK) | (WIDTH'(nib_sum) << (WIDTH - CHUNK));
        end
    end

    // NOTE: operand shift registers carry no reset; they are fully reloaded on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= b;
        end else if (state == BUSY) begin
            a_sh <= a_sh >> CHUNK;
            b_sh <= b_sh >> CHUNK;
        end
    end

    assign out_valid = (state == DONE);
    assign sum       = res_sh;
    assign c_out     = carry_r;

endmodule
